// File: rtl/ode_step_engine.sv
// ode_step_engine
//   Runs STEPS explicit-Euler steps of x' = A*x + B*u in signed saturating
//   Q(FRAC_BITS) fixed point. X ping-pongs between X_BASE and XNEW_BASE.
//   Each row is one multiply-accumulate pass over A (n terms) and B (m terms),
//   followed by the scaled update of X[i].
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   START, STEPS              one-cycle request and step count (sampled in IDLE)
//   BUSY, DONE, ERR           status; ERR is held until the next accepted START
//   RESULT_BASE               region holding the final X
//   INTERP_EN, INTERP_DONE    handshake with the interpolator before each step
//   RAM_ADD_RD1/2, RAM_DATA_RD1/2   two read ports, data one cycle after address
//   RAM_ADD_WR, RAM_DATA_WR, RAM_ENABLE_WR   single write port
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for START
// LOAD_NM   | address n and m
// CHECK     | capture n/m, validate dimensions and step count
// INTERP    | hold INTERP_EN until INTERP_DONE
// LOAD_H    | address h
// CAP_H     | capture h, clear accumulator
// ROW_A     | stream A[i][j] * X[j], j = 0..n-1
// ROW_B     | stream B[i][k] * U[k], k = 0..m-1 (skipped when m == 0)
// ROW_X     | address X[i], last product lands in acc
// WRITE     | write updated X[i] into dst, advance row
// NEXT_STEP | count down steps, swap src/dst or finish
// DONE      | one-cycle DONE pulse
module ode_step_engine #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 8,
  parameter int ACC_WIDTH     = 40,
  parameter int MAX_N         = 50,
  parameter int MAX_M         = 50,
  parameter int STEP_WIDTH    = 8,
  parameter int N_ADD         = 0,
  parameter int M_ADD         = 1,
  parameter int H_ADD         = 4,
  parameter int A_BASE        = 7,
  parameter int B_BASE        = 2507,
  parameter int X_BASE        = 5207,
  parameter int U_BASE        = 5257,
  parameter int XNEW_BASE     = 5407
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [STEP_WIDTH-1:0]    STEPS,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [ADDRESS_WIDTH-1:0] RESULT_BASE,
  output logic                     INTERP_EN,
  input  logic                     INTERP_DONE,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
  output logic [DATA_WIDTH-1:0]    RAM_DATA_WR,
  output logic                     RAM_ENABLE_WR
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  localparam logic [AW-1:0] N_ADDR    = AW'(N_ADD);
  localparam logic [AW-1:0] M_ADDR    = AW'(M_ADD);
  localparam logic [AW-1:0] H_ADDR    = AW'(H_ADD);
  localparam logic [AW-1:0] A_ADDR    = AW'(A_BASE);
  localparam logic [AW-1:0] B_ADDR    = AW'(B_BASE);
  localparam logic [AW-1:0] X_ADDR    = AW'(X_BASE);
  localparam logic [AW-1:0] U_ADDR    = AW'(U_BASE);
  localparam logic [AW-1:0] XNEW_ADDR = AW'(XNEW_BASE);
  localparam logic [AW-1:0] A_STRIDE  = AW'(MAX_N);
  localparam logic [AW-1:0] B_STRIDE  = AW'(MAX_M);

  localparam logic [DW-1:0]         MAX_N_W  = DW'(MAX_N);
  localparam logic [DW-1:0]         MAX_M_W  = DW'(MAX_M);
  localparam logic [DW-1:0]         DW_ZERO  = '0;
  localparam logic [DW-1:0]         DW_ONE   = DW'(1);
  localparam logic [STEP_WIDTH-1:0] STEP_ZERO = '0;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

  // Saturation bounds expressed at accumulator width so every intermediate
  // can be clamped by the same function.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_NM, S_CHECK, S_INTERP, S_LOAD_H, S_CAP_H,
    S_ROW_A, S_ROW_B, S_ROW_X, S_WRITE, S_NEXT_STEP, S_DONE
  } state_t;

  function automatic logic signed [DW-1:0] sat_w(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      sat_w = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) sat_w = SAT_MIN[DW-1:0];
    else                  sat_w = v[DW-1:0];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic signed [DW-1:0] v);
    sext_w = {{(ACC_WIDTH-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext_2w(input logic signed [2*DW-1:0] v);
    sext_2w = {{(ACC_WIDTH-2*DW){v[2*DW-1]}}, v};
  endfunction

  state_t                        state_q, state_d;
  logic [STEP_WIDTH-1:0]         steps_q, steps_d;
  logic [DW-1:0]                 n_q, n_d;
  logic [DW-1:0]                 m_q, m_d;
  logic signed [DW-1:0]          h_q, h_d;
  logic [DW-1:0]                 col_q, col_d;
  logic [DW-1:0]                 row_q, row_d;
  logic [AW-1:0]                 a_row_q, a_row_d;
  logic [AW-1:0]                 b_row_q, b_row_d;
  logic [AW-1:0]                 src_q, src_d;
  logic [AW-1:0]                 dst_q, dst_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          acc_en_q, acc_en_d;
  logic                          err_q, err_d;
  logic [AW-1:0]                 result_base_q, result_base_d;

  logic signed [2*DW-1:0]        prod;
  logic signed [DW-1:0]          f_w;
  logic signed [2*DW-1:0]        hf;
  logic signed [DW-1:0]          g_w;
  logic signed [DW-1:0]          x_new;

  // Row update datapath; only consumed in WRITE, where RAM_DATA_RD1 holds X[i]
  // and acc_q holds the complete row sum.
  always_comb begin
    prod  = $signed(RAM_DATA_RD1) * $signed(RAM_DATA_RD2);
    f_w   = sat_w(acc_q >>> FRAC_BITS);
    hf    = h_q * f_w;
    g_w   = sat_w(sext_2w(hf) >>> FRAC_BITS);
    x_new = sat_w(sext_w($signed(RAM_DATA_RD1)) + sext_w(g_w));
  end

  always_comb begin
    state_d       = state_q;
    steps_d       = steps_q;
    n_d           = n_q;
    m_d           = m_q;
    h_d           = h_q;
    col_d         = col_q;
    row_d         = row_q;
    a_row_d       = a_row_q;
    b_row_d       = b_row_q;
    src_d         = src_q;
    dst_d         = dst_q;
    err_d         = err_q;
    result_base_d = result_base_q;
    acc_en_d      = 1'b0;
    // A product is added one cycle after its addresses were issued.
    acc_d         = acc_en_q ? (acc_q + sext_2w(prod)) : acc_q;

    DONE          = 1'b0;
    INTERP_EN     = 1'b0;
    RAM_ADD_RD1   = '0;
    RAM_ADD_RD2   = '0;
    RAM_ADD_WR    = '0;
    RAM_DATA_WR   = '0;
    RAM_ENABLE_WR = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          steps_d = STEPS;
          err_d   = 1'b0;
          state_d = S_LOAD_NM;
        end
      end
      S_LOAD_NM: begin
        RAM_ADD_RD1 = N_ADDR;
        RAM_ADD_RD2 = M_ADDR;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        n_d = RAM_DATA_RD1;
        m_d = RAM_DATA_RD2;
        if ((RAM_DATA_RD1 == DW_ZERO) || (RAM_DATA_RD1 > MAX_N_W) ||
            (RAM_DATA_RD2 > MAX_M_W) || (steps_q == STEP_ZERO)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          src_d   = X_ADDR;
          dst_d   = XNEW_ADDR;
          row_d   = '0;
          a_row_d = A_ADDR;
          b_row_d = B_ADDR;
          state_d = S_INTERP;
        end
      end
      S_INTERP: begin
        INTERP_EN   = 1'b1;
        RAM_ADD_RD1 = H_ADDR;
        if (INTERP_DONE) state_d = S_LOAD_H;
      end
      S_LOAD_H: begin
        RAM_ADD_RD1 = H_ADDR;
        state_d     = S_CAP_H;
      end
      S_CAP_H: begin
        h_d     = $signed(RAM_DATA_RD1);
        acc_d   = '0;
        col_d   = '0;
        state_d = S_ROW_A;
      end
      S_ROW_A: begin
        RAM_ADD_RD1 = a_row_q + AW'(col_q);
        RAM_ADD_RD2 = src_q + AW'(col_q);
        acc_en_d    = 1'b1;
        if (col_q == n_q - DW_ONE) begin
          col_d   = '0;
          state_d = (m_q == DW_ZERO) ? S_ROW_X : S_ROW_B;
        end else begin
          col_d = col_q + DW_ONE;
        end
      end
      S_ROW_B: begin
        RAM_ADD_RD1 = b_row_q + AW'(col_q);
        RAM_ADD_RD2 = U_ADDR + AW'(col_q);
        acc_en_d    = 1'b1;
        if (col_q == m_q - DW_ONE) begin
          col_d   = '0;
          state_d = S_ROW_X;
        end else begin
          col_d = col_q + DW_ONE;
        end
      end
      S_ROW_X: begin
        RAM_ADD_RD1 = src_q + AW'(row_q);
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        RAM_ADD_WR    = dst_q + AW'(row_q);
        RAM_DATA_WR   = x_new;
        RAM_ENABLE_WR = 1'b1;
        row_d         = row_q + DW_ONE;
        a_row_d       = a_row_q + A_STRIDE;
        b_row_d       = b_row_q + B_STRIDE;
        acc_d         = '0;
        col_d         = '0;
        state_d       = (row_q == n_q - DW_ONE) ? S_NEXT_STEP : S_ROW_A;
      end
      S_NEXT_STEP: begin
        steps_d = steps_q - STEP_ONE;
        if (steps_q > STEP_ONE) begin
          src_d   = dst_q;
          dst_d   = src_q;
          row_d   = '0;
          a_row_d = A_ADDR;
          b_row_d = B_ADDR;
          state_d = S_INTERP;
        end else begin
          result_base_d = dst_q;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ERR         = err_q;
  assign RESULT_BASE = result_base_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      steps_q       <= '0;
      n_q           <= '0;
      m_q           <= '0;
      h_q           <= '0;
      col_q         <= '0;
      row_q         <= '0;
      a_row_q       <= A_ADDR;
      b_row_q       <= B_ADDR;
      src_q         <= X_ADDR;
      dst_q         <= XNEW_ADDR;
      acc_q         <= '0;
      acc_en_q      <= 1'b0;
      err_q         <= 1'b0;
      result_base_q <= X_ADDR;
    end else begin
      state_q       <= state_d;
      steps_q       <= steps_d;
      n_q           <= n_d;
      m_q           <= m_d;
      h_q           <= h_d;
      col_q         <= col_d;
      row_q         <= row_d;
      a_row_q       <= a_row_d;
      b_row_q       <= b_row_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      acc_q         <= acc_d;
      acc_en_q      <= acc_en_d;
      err_q         <= err_d;
      result_base_q <= result_base_d;
    end
  end

endmodule
